// File: rtl/corefifo_ptr_sync_pkg.sv
// Shared constants and helpers for the multi-channel FIFO pointer synchroniser.
// Build option: COREFIFO_PTR_SYNC_GRAY_DECODE_EN selects binary output decoding.
package corefifo_ptr_sync_pkg;

  localparam int MAX_STAGES = 8;
  localparam int MAX_CH     = 8;
  localparam int MIN_STAGES = 2;
  localparam int GRAY_MAX_W = 32;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // Upper bits are zero for narrower pointers, so they decode to zero as well.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
    logic [GRAY_MAX_W-1:0] bin;
    bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/corefifo_ptr_sync_ch.sv
// One pointer channel: flop chain into clk, stability qualifier and accept register.
// Build option: COREFIFO_PTR_SYNC_GRAY_DECODE_EN makes sync_out carry the binary pointer.
module corefifo_ptr_sync_ch
  import corefifo_ptr_sync_pkg::*;
#(
  parameter int NUM_STAGES    = 2,
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [WIDTH-1:0] inp,
  output logic [WIDTH-1:0] sync_out,
  output logic             sync_valid,
  output logic             sync_stable
);

  localparam int CNT_W = (STABLE_CYCLES == 0) ? 1 : clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [WIDTH-1:0] stage [NUM_STAGES];
  logic [WIDTH-1:0] fin;
  logic [WIDTH-1:0] fin_out;
  logic [WIDTH-1:0] last_q;
  logic [WIDTH-1:0] acc_gray;
  logic [CNT_W-1:0] cnt;
  logic             qualified;
  logic             accept;

  assign fin = stage[NUM_STAGES-1];

  // A stale saturated count must not qualify a value that only just arrived.
  assign qualified = (STABLE_CYCLES == 0) || ((cnt == CNT_MAX) && (fin == last_q));
  assign accept    = qualified && (fin != acc_gray);

`ifdef COREFIFO_PTR_SYNC_GRAY_DECODE_EN
  assign fin_out = WIDTH'(gray2bin(GRAY_MAX_W'(fin)));
`else
  assign fin_out = fin;
`endif

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        stage[i] <= '0;
      end
      last_q      <= '0;
      cnt         <= '0;
      acc_gray    <= '0;
      sync_out    <= '0;
      sync_valid  <= 1'b0;
      sync_stable <= 1'b0;
    end else begin
      stage[0] <= inp;
      for (int i = 1; i < NUM_STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
      last_q <= fin;
      if (fin != last_q) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
      sync_valid  <= accept;
      sync_stable <= qualified && ((fin == acc_gray) || accept);
      if (accept) begin
        acc_gray <= fin;
        sync_out <= fin_out;
      end
    end
  end

endmodule

// File: rtl/corefifo_ptr_sync_multi.sv
// NUM_CH independent gray pointer synchronisers with stability qualification.
// Build option: COREFIFO_PTR_SYNC_GRAY_DECODE_EN decodes sync_out to binary.
module corefifo_ptr_sync_multi
  import corefifo_ptr_sync_pkg::*;
#(
  parameter int NUM_STAGES    = 2,
  parameter int ADDRWIDTH     = 3,
  parameter int NUM_CH        = 1,
  parameter int STABLE_CYCLES = 1
) (
  input  logic                            clk,
  input  logic                            srst,
  input  logic [NUM_CH*(ADDRWIDTH+1)-1:0] inp,
  output logic [NUM_CH*(ADDRWIDTH+1)-1:0] sync_out,
  output logic [NUM_CH-1:0]               sync_valid,
  output logic [NUM_CH-1:0]               sync_stable
);

  localparam int W = ADDRWIDTH + 1;

  // Out-of-range depths are pulled into the supported window rather than breaking the chain.
  localparam int STAGES = (NUM_STAGES < MIN_STAGES) ? MIN_STAGES :
                          (NUM_STAGES > MAX_STAGES) ? MAX_STAGES : NUM_STAGES;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    corefifo_ptr_sync_ch #(
      .NUM_STAGES   (STAGES),
      .WIDTH        (W),
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_ch (
      .clk        (clk),
      .srst       (srst),
      .inp        (inp[c*W +: W]),
      .sync_out   (sync_out[c*W +: W]),
      .sync_valid (sync_valid[c]),
      .sync_stable(sync_stable[c])
    );
  end

endmodule

// File: tb/tb_corefifo_ptr_sync_multi.sv
// Scoreboard bench for corefifo_ptr_sync_multi across three parameter sets.
// Honours COREFIFO_PTR_SYNC_GRAY_DECODE_EN when computing expected outputs.
module tb_corefifo_ptr_sync_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        srst_a, srst_b, srst_c;
  logic [2:0]  inp_a, out_a;
  logic [0:0]  valid_a, stable_a;
  logic [11:0] inp_b, out_b;
  logic [2:0]  valid_b, stable_b;
  logic [7:0]  inp_c, out_c;
  logic [1:0]  valid_c, stable_c;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          dut;
    int          ch;
    int          cyc;
    logic [15:0] val;
  } exp_t;
  exp_t sb[$];

  corefifo_ptr_sync_multi #(.NUM_STAGES(2), .ADDRWIDTH(2), .NUM_CH(1), .STABLE_CYCLES(1)) u_dut_a (
    .clk(clk), .srst(srst_a), .inp(inp_a), .sync_out(out_a), .sync_valid(valid_a), .sync_stable(stable_a));

  corefifo_ptr_sync_multi #(.NUM_STAGES(3), .ADDRWIDTH(3), .NUM_CH(3), .STABLE_CYCLES(2)) u_dut_b (
    .clk(clk), .srst(srst_b), .inp(inp_b), .sync_out(out_b), .sync_valid(valid_b), .sync_stable(stable_b));

  corefifo_ptr_sync_multi #(.NUM_STAGES(2), .ADDRWIDTH(3), .NUM_CH(2), .STABLE_CYCLES(0)) u_dut_c (
    .clk(clk), .srst(srst_c), .inp(inp_c), .sync_out(out_c), .sync_valid(valid_c), .sync_stable(stable_c));

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] expOut(input logic [15:0] g);
`ifdef COREFIFO_PTR_SYNC_GRAY_DECODE_EN
    logic [15:0] b;
    for (int i = 0; i < 16; i++) b[i] = ^(g >> i);
    return b;
`else
    return g;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic scoreChannel(input int dut, input int ch, input logic [15:0] val);
    int idx;
    idx = -1;
    for (int i = 0; i < sb.size(); i++) begin
      if (idx < 0 && sb[i].dut == dut && sb[i].ch == ch) idx = i;
    end
    if (idx < 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_pulse dut%0d ch%0d: got sync_valid=1 value %h at cycle %0d, required no pulse",
               dut, ch, val, cyc);
    end else begin
      checkOutput($sformatf("pulse_value dut%0d ch%0d", dut, ch), val, sb[idx].val);
      checkOutput($sformatf("pulse_cycle dut%0d ch%0d", dut, ch), 16'(cyc), 16'(sb[idx].cyc));
      sb.delete(idx);
    end
  endtask

  // Monitor: every sync_valid pulse must match the oldest pending expectation for its channel.
  always @(negedge clk) begin
    if (valid_a[0]) scoreChannel(0, 0, 16'(out_a));
    for (int c = 0; c < 3; c++) if (valid_b[c]) scoreChannel(1, c, 16'(out_b[c*4 +: 4]));
    for (int c = 0; c < 2; c++) if (valid_c[c]) scoreChannel(2, c, 16'(out_c[c*4 +: 4]));
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int dut, input int ch, input logic [3:0] value);
    case (dut)
      0:       inp_a = value[2:0];
      1:       inp_b[ch*4 +: 4] = value;
      default: inp_c[ch*4 +: 4] = value;
    endcase
  endtask

  task automatic expectPulse(input int dut, input int ch, input int lat, input logic [3:0] gray);
    exp_t e;
    e.dut = dut;
    e.ch  = ch;
    e.cyc = cyc + lat;
    e.val = expOut(16'(gray));
    sb.push_back(e);
  endtask

  initial begin
    srst_a = 1'b1; srst_b = 1'b1; srst_c = 1'b1;
    inp_a = '1; inp_b = '1; inp_c = '1;
    waitCycles(3);
    checkOutput("reset_out_a", 16'(out_a), 16'h0);
    checkOutput("reset_valid_a", 16'(valid_a), 16'h0);
    checkOutput("reset_stable_a", 16'(stable_a), 16'h0);
    checkOutput("reset_out_b", 16'(out_b), 16'h0);
    checkOutput("reset_valid_b", 16'(valid_b), 16'h0);
    checkOutput("reset_stable_b", 16'(stable_b), 16'h0);
    checkOutput("reset_out_c", 16'(out_c), 16'h0);
    checkOutput("reset_valid_c", 16'(valid_c), 16'h0);
    checkOutput("reset_stable_c", 16'(stable_c), 16'h0);

    inp_a = '0; inp_b = '0; inp_c = '0;
    srst_a = 1'b0; srst_b = 1'b0; srst_c = 1'b0;
    waitCycles(20);
    checkOutput("idle_out_a", 16'(out_a), 16'h0);
    checkOutput("idle_stable_a", 16'(stable_a), 16'h1);
    checkOutput("idle_stable_b", 16'(stable_b), 16'h7);
    checkOutput("idle_stable_c", 16'(stable_c), 16'h3);

    // NUM_STAGES=2, STABLE_CYCLES=1: five edges to accept.
    applyStimulus(0, 0, 4'b0001);
    expectPulse(0, 0, 5, 4'b0001);
    waitCycles(8);
    checkOutput("latency_out_a", 16'(out_a), expOut(16'b001));
    checkOutput("latency_stable_a", 16'(stable_a), 16'h1);

    applyStimulus(0, 0, 4'b0100);
    expectPulse(0, 0, 5, 4'b0100);
    waitCycles(8);
    checkOutput("wrap_top_out_a", 16'(out_a), expOut(16'b100));
    applyStimulus(0, 0, 4'b0000);
    expectPulse(0, 0, 5, 4'b0000);
    waitCycles(8);
    checkOutput("wrap_zero_out_a", 16'(out_a), 16'h0);

    // Reset lands while 010 is still in the chain; it is re-acquired afterwards.
    applyStimulus(0, 0, 4'b0010);
    expectPulse(0, 0, 7, 4'b0010);
    waitCycles(1);
    srst_a = 1'b1;
    waitCycles(1);
    srst_a = 1'b0;
    checkOutput("midreset_out_a", 16'(out_a), 16'h0);
    checkOutput("midreset_stable_a", 16'(stable_a), 16'h0);
    waitCycles(10);
    checkOutput("midreset_final_out_a", 16'(out_a), expOut(16'b010));

    // Glitch filter on dut b channel 0: alternating input never qualifies.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 0, (i % 2 == 0) ? 4'b0011 : 4'b0001);
      waitCycles(1);
    end
    checkOutput("glitch_hold_out_b0", 16'(out_b[3:0]), 16'h0);
    applyStimulus(1, 0, 4'b0011);
    expectPulse(1, 0, 7, 4'b0011);
    waitCycles(10);
    checkOutput("glitch_settle_out_b0", 16'(out_b[3:0]), expOut(16'b0011));

    applyStimulus(1, 1, 4'b0110);
    expectPulse(1, 1, 7, 4'b0110);
    waitCycles(10);
    checkOutput("multi_out_b0", 16'(out_b[3:0]), expOut(16'b0011));
    checkOutput("multi_out_b1", 16'(out_b[7:4]), expOut(16'b0110));
    checkOutput("multi_out_b2", 16'(out_b[11:8]), 16'h0);

    applyStimulus(1, 0, 4'b0010);
    applyStimulus(1, 2, 4'b1000);
    expectPulse(1, 0, 7, 4'b0010);
    expectPulse(1, 2, 7, 4'b1000);
    waitCycles(10);

    // Short excursion away from the accepted value and back yields nothing.
    applyStimulus(1, 1, 4'b0111);
    waitCycles(2);
    applyStimulus(1, 1, 4'b0110);
    waitCycles(10);
    checkOutput("return_out_b1", 16'(out_b[7:4]), expOut(16'b0110));

    // STABLE_CYCLES=0: three edges to accept.
    applyStimulus(2, 1, 4'b0101);
    expectPulse(2, 1, 3, 4'b0101);
    waitCycles(6);
    checkOutput("noqual_out_c1", 16'(out_c[7:4]), expOut(16'b0101));
    applyStimulus(2, 0, 4'b1000);
    applyStimulus(2, 1, 4'b0000);
    expectPulse(2, 0, 3, 4'b1000);
    expectPulse(2, 1, 3, 4'b0000);
    waitCycles(6);
    applyStimulus(2, 0, 4'b0000);
    expectPulse(2, 0, 3, 4'b0000);
    waitCycles(6);
    checkOutput("noqual_wrap_out_c", 16'(out_c), 16'h0);

    waitCycles(12);
    while (sb.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL missing_pulse dut%0d ch%0d: got no sync_valid, required value %h at cycle %0d",
               sb[0].dut, sb[0].ch, sb[0].val, sb[0].cyc);
      sb.delete(0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
